// File: rtl/mult_seq_controller.sv
// Sequential sign-magnitude multiplier: N-cycle shift-and-add over the magnitudes, sign = X ^ Y.
// Define MULT_ZERO_SIGN_CLEAR_EN to force a zero product to carry a positive sign.
module mult_seq_controller #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             X_signal,
    input  logic [N-1:0]     X_mag,
    input  logic             Y_signal,
    input  logic [N-1:0]     Y_mag,
    output logic             busy,
    output logic             done,
    output logic             Mult_signal,
    output logic [2*N-1:0]   Mult_mag
);

    localparam int W2    = 2 * N;
    localparam int CNT_W = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic [W2-1:0]   mcand_q, mcand_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [W2-1:0]   mag_q, mag_d;
    logic [N-1:0]    mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            sign_q, sign_d;
    logic            msign_q, msign_d;
    logic [W2-1:0]   acc_sum;
    logic            last_iter;
    logic            final_sign;

    assign last_iter = (cnt_q == CNT_W'(N - 1));
    assign acc_sum   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

`ifdef MULT_ZERO_SIGN_CLEAR_EN
    assign final_sign = sign_q & (acc_sum != '0);
`else
    assign final_sign = sign_q;
`endif

    // State register
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so no path through the case leaves a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        Mult_mag    = mag_q;
        Mult_signal = msign_q;
    end

    // Datapath next values
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        msign_d  = msign_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = W2'(X_mag);
                    mplier_d = Y_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                    sign_d   = X_signal ^ Y_signal;
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                // Results are published only on the final iteration, so they hold during RUN.
                if (last_iter) begin
                    mag_d   = acc_sum;
                    msign_d = final_sign;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            mag_q    <= '0;
            msign_q  <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            mag_q    <= mag_d;
            msign_q  <= msign_d;
        end
    end

endmodule

// File: tb/tb_mult_seq_controller.sv
// Self-checking bench for mult_seq_controller: vector table, multi-cycle corner sequences,
// back-to-back operation and randomized operands against an arithmetic reference model.
module tb_mult_seq_controller;

    localparam int N  = 8;
    localparam int W2 = 2 * N;
    localparam int PERIOD = N + 2;
    localparam int BUDGET = 40;
`ifdef MULT_ZERO_SIGN_CLEAR_EN
    localparam bit ZCLR = 1'b1;
`else
    localparam bit ZCLR = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          start;
    logic          X_signal, Y_signal;
    logic [N-1:0]  X_mag, Y_mag;
    logic          busy, done, Mult_signal;
    logic [W2-1:0] Mult_mag;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W2-1:0] last_mag;
    logic          last_sign;

    mult_seq_controller #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .X_signal   (X_signal),
        .X_mag      (X_mag),
        .Y_signal   (Y_signal),
        .Y_mag      (Y_mag),
        .busy       (busy),
        .done       (done),
        .Mult_signal(Mult_signal),
        .Mult_mag   (Mult_mag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          xs;
        logic [N-1:0]  xm;
        logic          ys;
        logic [N-1:0]  ym;
        logic [W2-1:0] mag;
        logic          sgn;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic product and sign rule
    function automatic logic [W2-1:0] model_mag(input logic [N-1:0] xm, input logic [N-1:0] ym);
        return W2'(xm) * W2'(ym);
    endfunction

    function automatic logic model_sign(input logic xs, input logic ys, input logic [W2-1:0] mag);
        if (ZCLR && mag == '0) return 1'b0;
        return xs ^ ys;
    endfunction

    // Called at a negedge, `lat0` edges after the accepting edge; waits for done.
    task automatic finish_op(input int lat0, input logic [W2-1:0] emag, input logic esign, input string tag);
        int  lat;
        int  bad_run;
        lat     = lat0;
        bad_run = 0;
        while (!done && lat < BUDGET) begin
            if (busy !== 1'b1 || Mult_mag !== last_mag || Mult_signal !== last_sign) bad_run++;
            @(negedge clk);
            lat++;
        end
        check({tag, " run_busy_hold"}, 32'(bad_run), 32'd0);
        check({tag, " latency"}, 32'(lat), 32'(N));
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy_in_done"}, 32'(busy), 32'd1);
        check({tag, " mag"}, 32'(Mult_mag), 32'(emag));
        check({tag, " sign"}, 32'(Mult_signal), 32'(esign));
        @(negedge clk);
        check({tag, " idle_after"}, {30'd0, busy, done}, 32'd0);
        check({tag, " mag_hold"}, 32'(Mult_mag), 32'(emag));
        last_mag  = emag;
        last_sign = esign;
    endtask

    task automatic run_op(input logic xs, input logic [N-1:0] xm, input logic ys, input logic [N-1:0] ym,
                          input logic [W2-1:0] emag, input logic esign, input string tag);
        X_signal = xs; X_mag = xm; Y_signal = ys; Y_mag = ym;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble operands: only the accepting edge matters
        X_signal = 1'($urandom); X_mag = N'($urandom);
        Y_signal = 1'($urandom); Y_mag = N'($urandom);
        finish_op(0, emag, esign, tag);
    endtask

    vec_t vecs[6];
    logic          bxs[3*PERIOD];
    logic          bys[3*PERIOD];
    logic [N-1:0]  bxm[3*PERIOD];
    logic [N-1:0]  bym[3*PERIOD];

    initial begin
        int bad;
        int extra;
        logic [W2-1:0] em;

        vecs[0] = '{1'b1, 8'd3,   1'b0, 8'd5,   16'h000F, 1'b1};
        vecs[1] = '{1'b1, 8'd255, 1'b1, 8'd255, 16'hFE01, 1'b0};
        vecs[2] = '{1'b1, 8'd0,   1'b0, 8'd77,  16'h0000, ~ZCLR};
        vecs[3] = '{1'b0, 8'd0,   1'b0, 8'd0,   16'h0000, 1'b0};
        vecs[4] = '{1'b0, 8'd255, 1'b1, 8'd1,   16'h00FF, 1'b1};
        vecs[5] = '{1'b0, 8'd128, 1'b0, 8'd2,   16'h0100, 1'b0};

        reset = 1'b1; start = 1'b0;
        X_signal = 1'b0; X_mag = '0; Y_signal = 1'b0; Y_mag = '0;
        last_mag = '0; last_sign = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset mag", 32'(Mult_mag), 32'd0);
        check("reset sign", 32'(Mult_signal), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i])
            run_op(vecs[i].xs, vecs[i].xm, vecs[i].ys, vecs[i].ym, vecs[i].mag, vecs[i].sgn,
                   $sformatf("vec%0d", i));

        // start while busy is ignored, operand change after acceptance has no effect
        X_signal = 1'b0; X_mag = 8'd4; Y_signal = 1'b0; Y_mag = 8'd6; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        X_mag = 8'd9; Y_mag = 8'd9; start = 1'b1;
        @(negedge clk); start = 1'b0; X_mag = 8'd200;
        finish_op(3, 16'd24, 1'b0, "busy_start");
        extra = 0;
        repeat (N + 4) begin
            if (done) extra++;
            @(negedge clk);
        end
        check("busy_start no_second_done", 32'(extra), 32'd0);

        // Reset mid-run abandons the operation
        X_signal = 1'b1; X_mag = 8'd7; Y_signal = 1'b0; Y_mag = 8'd7; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset mag", 32'(Mult_mag), 32'd0);
        check("midreset sign", 32'(Mult_signal), 32'd0);
        extra = 0;
        repeat (N + 4) begin
            if (done || busy) extra++;
            @(negedge clk);
        end
        check("midreset quiet", 32'(extra), 32'd0);
        last_mag = '0; last_sign = 1'b0;
        run_op(1'b0, 8'd2, 1'b0, 8'd3, 16'd6, 1'b0, "after_reset");

        // Back-to-back with start held high: accepts every N+2 cycles
        bad = 0;
        for (int c = 0; c < 3 * PERIOD; c++) begin
            bxs[c] = 1'($urandom); bys[c] = 1'($urandom);
            bxm[c] = N'($urandom); bym[c] = N'($urandom);
            X_signal = bxs[c]; X_mag = bxm[c]; Y_signal = bys[c]; Y_mag = bym[c];
            start = 1'b1;
            @(negedge clk);
            if (busy !== ((c % PERIOD) != PERIOD - 1)) bad++;
            if (done !== ((c % PERIOD) == N)) bad++;
            if ((c % PERIOD) == N) begin
                em = model_mag(bxm[c-N], bym[c-N]);
                check($sformatf("b2b mag c%0d", c), 32'(Mult_mag), 32'(em));
                check($sformatf("b2b sign c%0d", c), 32'(Mult_signal),
                      32'(model_sign(bxs[c-N], bys[c-N], em)));
                last_mag  = em;
                last_sign = model_sign(bxs[c-N], bys[c-N], em);
            end
        end
        start = 1'b0;
        check("b2b busy_done_pattern", 32'(bad), 32'd0);

        // Randomized operands against the reference model
        for (int r = 0; r < 20; r++) begin
            logic          xs, ys;
            logic [N-1:0]  xm, ym;
            xs = 1'($urandom); ys = 1'($urandom);
            xm = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            ym = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            em = model_mag(xm, ym);
            run_op(xs, xm, ys, ym, em, model_sign(xs, ys, em), $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
